// File: rtl/serial_subtractor16.sv
// ----------------------------------------------------------------------------
// serial_subtractor16
//
// Multi-cycle subtractor computing DIFF = A - B - BIN (mod 2^WIDTH). The
// operands are latched on the accepting edge and processed one SLICE-bit slice
// per clock, least-significant slice first. The borrow is carried between
// slices in a register, so only one SLICE-wide adder is needed.
//
// Timing (defaults, N = WIDTH/SLICE = 2):
//   c0 : START sampled with READY=1
//   c1 : RUN, slice 0
//   c2 : RUN, slice 1
//   c3 : DONE=1, results valid and newly updated
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   asynchronous active-high reset
//   START  in   request, sampled only while READY=1
//   A      in   minuend   [WIDTH-1:0], captured on accept
//   B      in   subtrahend[WIDTH-1:0], captured on accept
//   BIN    in   borrow in, captured on accept
//   READY  out  block can accept START this cycle (IDLE or DONE)
//   DONE   out  one-cycle pulse, result outputs newly updated
//   DIFF   out  A - B - BIN modulo 2^WIDTH
//   BOUT   out  unsigned borrow out (A < B + BIN)
//   ZERO   out  DIFF == 0
//   NEG    out  DIFF[WIDTH-1]
//   OVF    out  signed overflow of the two's-complement subtraction
// ----------------------------------------------------------------------------
module serial_subtractor16 #(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  // Slice datapath: next working register and next borrow for the current slice.
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] work_d;
  logic             borrow_d;
  logic             last_slice;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    a_slice    = a_q[int'(idx_q) * SLICE +: SLICE];
    b_slice    = b_q[int'(idx_q) * SLICE +: SLICE];
    // Subtraction as addition of the one's complement; the incoming borrow is
    // inverted into a carry-in, and the carry-out inverted back into a borrow.
    slice_sum  = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE{1'b0}}, ~borrow_q};
    work_d     = work_q;
    work_d[int'(idx_q) * SLICE +: SLICE] = slice_sum[SLICE-1:0];
    borrow_d   = ~slice_sum[SLICE];
    last_slice = (idx_q == IW'(N - 1));
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
        S_IDLE, S_DONE: begin
          if (START) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= BIN;
            idx_q    <= '0;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end

        S_RUN: begin
          work_q   <= work_d;
          borrow_q <= borrow_d;
          if (last_slice) begin
            idx_q   <= '0;
            state_q <= S_DONE;
            // Flags come from the full-width result including this last slice.
            diff_q  <= work_d;
            bout_q  <= borrow_d;
            zero_q  <= (work_d == '0);
            neg_q   <= work_d[WIDTH-1];
            ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                       (work_d[WIDTH-1] != a_q[WIDTH-1]);
          end else begin
            idx_q   <= idx_q + IW'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign READY = (state_q != S_RUN);
  assign DONE  = (state_q == S_DONE);
  assign DIFF  = diff_q;
  assign BOUT  = bout_q;
  assign ZERO  = zero_q;
  assign NEG   = neg_q;
  assign OVF   = ovf_q;

endmodule
